// File: rtl/gf233_sqr_seq.sv
// Computes A^(2^K) in GF(2^233), field polynomial x^233 + x^74 + 1, by iterating
// SQ_PER_CYCLE chained squarers over a working register under a valid/ready handshake.
module gf233_sqr_seq #(
    parameter int WIDTH        = 233,
    parameter int SQ_PER_CYCLE = 1,
    parameter int CNT_W        = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] DIN,
    input  logic [CNT_W-1:0] K,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] DOUT,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic             BUSY
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Squaring spreads bit i to bit 2i; each high term x^j folds to x^(j-159) + x^(j-233).
    // Folding from the top down lets terms landing above 232 be folded again later.
    function automatic logic [WIDTH-1:0] gf_sqr(input logic [WIDTH-1:0] a);
        logic [2*WIDTH-2:0] t;
        t = '0;
        for (int i = 0; i < WIDTH; i++) begin
            t[2*i] = a[i];
        end
        for (int j = 2*WIDTH-2; j >= WIDTH; j--) begin
            t[j-(WIDTH-74)] = t[j-(WIDTH-74)] ^ t[j];
            t[j-WIDTH]      = t[j-WIDTH] ^ t[j];
        end
        return t[WIDTH-1:0];
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] sq1_s, sq2_s, sq_sel_s;
    logic [CNT_W-1:0] step_s;
    logic             two_step_s;

    assign sq1_s = gf_sqr(work_q);
    assign sq2_s = gf_sqr(sq1_s);

    // Step size: two squarings only when the second chained stage exists and enough remain.
    always_comb begin
        two_step_s = (SQ_PER_CYCLE == 2) && (rem_q >= CNT_W'(2));
        if (two_step_s) begin
            sq_sel_s = sq2_s;
            step_s   = CNT_W'(2);
        end else begin
            sq_sel_s = sq1_s;
            step_s   = CNT_W'(1);
        end
    end

    // Next-state, datapath and output-flag computation.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (IN_VALID) begin
                    work_d  = DIN;
                    rem_d   = K;
                    state_d = (K == {CNT_W{1'b0}}) ? DONE : RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                work_d  = sq_sel_s;
                rem_d   = rem_q - step_s;
                state_d = (rem_d == {CNT_W{1'b0}}) ? DONE : RUN;
            end
            DONE: begin
                if (OUT_READY) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        out_valid_d = (state_d == DONE);
        in_ready_d  = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    // State, working register and registered handshake flags.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            work_q      <= '0;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            rem_q       <= rem_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign DOUT      = work_q;
    assign OUT_VALID = out_valid_q;
    assign IN_READY  = in_ready_q;
    assign BUSY      = busy_q;

endmodule

// File: doc/gf233_sqr_seq.md
Name: gf233_sqr_seq

Overview:
- Sequencer for the GF(2^233) squarer, field polynomial x^233 + x^74 + 1. It computes A^(2^K), i.e. K repeated squarings of a field element, by feeding squarer output back through a working register.
- Used by the Itoh-Tsujii inversion and point-arithmetic controllers in the ECC signing core.
- Instantiates SQ_PER_CYCLE chained copies of the existing combinational squarer. Valid/ready handshake on both input and output sides.

Parameters:
- WIDTH, 233, field element width; fixed by the squarer, and no other value is supported.
- SQ_PER_CYCLE, 1, number of squarer instances chained per cycle; legal values are 1 and 2.
- CNT_W, 8, width of the squaring-count input K.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous active-low reset.
- DIN  input  WIDTH  operand A, polynomial basis, bit i = coefficient of x^i.
- K  input  CNT_W  number of squarings to apply, 0..2^CNT_W-1.
- IN_VALID  input  1  DIN/K are valid.
- IN_READY  output  1  block can accept an operand.
- DOUT  output  WIDTH  result A^(2^K).
- OUT_VALID  output  1  DOUT is valid.
- OUT_READY  input  1  consumer accepts DOUT.
- BUSY  output  1  high whenever state is not IDLE.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, working register=0, remaining count=0, DOUT=0, OUT_VALID=0, IN_READY=1, BUSY=0.
- States: IDLE, RUN, DONE.
- IN_READY=1 only in IDLE. Accept occurs on a rising edge where IN_VALID && IN_READY.
- On accept: working register <= DIN and remaining <= K.
  - If K==0: go to DONE.
  - Otherwise: go to RUN.
- DIN and K are sampled only at accept and ignored at all other times.
- RUN, each cycle:
  - step = min(remaining, SQ_PER_CYCLE).
  - working register <= the register squared step times.
  - remaining <= remaining - step.
  - If the new remaining is 0: go to DONE.
- With SQ_PER_CYCLE=2 and odd K, the final RUN cycle applies one squaring: the output of the first chained squarer is selected by a mux.
- Latency: accept at edge t. OUT_VALID rises after edge t+ceil(K/SQ_PER_CYCLE), so it rises after edge t when K=0.
- DONE:
  - OUT_VALID=1; DOUT = working register, held stable.
  - Stays in DONE while OUT_READY=0, with no limit on the number of stall cycles.
  - When OUT_READY=1: go to IDLE; OUT_VALID drops after that edge.
  - The earliest next accept is the following edge.
- DOUT is driven directly from the working register (registered output, no combinational path from DIN to DOUT).
- IN_VALID asserted in RUN or DONE has no effect; the operand is not queued.
- The remaining counter is CNT_W bits and never underflows; step selection guarantees remaining ≥ step.
- Reset asserted mid-RUN or in DONE: return immediately (asynchronously) to the reset values. The in-flight result is discarded and no OUT_VALID pulse is emitted afterwards.
- K = 233·n yields DOUT = DIN (Frobenius period 233). The block does not shortcut this case and always performs all K squarings.
- BUSY = (state != IDLE).

Test Plan:
- Pass-through and trivial element: DIN = x^5 (bit 5 only), K=0 → OUT_VALID one cycle after accept, DOUT = x^5. Then DIN = 1, K=200 → DOUT = 1.
- Single squaring with reduction:
  - DIN = bit 117 only, K=1 → DOUT = bits 1 and 75 set (x^234 = x^75 + x).
  - DIN = bit 116 only, K=1 → DOUT = bit 232 only.
- Frobenius identity: random DIN, K=233 → DOUT == DIN.
  - SQ_PER_CYCLE=1: OUT_VALID after 233 RUN cycles.
  - SQ_PER_CYCLE=2: OUT_VALID after 117 RUN cycles, with a single-square final step.
- Chained count check: random A, K=3 → DOUT equals a software model of A^8 mod (x^233+x^74+1). Also K=255 compared against the model.
- Back-pressure: OUT_READY held low 10 cycles in DONE → DOUT and OUT_VALID stable, IN_READY=0, a new IN_VALID is ignored. On OUT_READY=1 the block returns to IDLE, and the next operand is accepted one cycle later.
- Reset mid-operation: assert RST_N=0 in cycle 50 of a K=200 run → outputs go to reset values immediately. After release, no OUT_VALID appears; a fresh DIN=bit 1, K=1 yields DOUT = bit 2.
